// File: rtl/shift_unit_mc.sv
// Multi-cycle logarithmic shifter: one power-of-two stage per clock, largest first.
// Optional feature macro: SHIFT_ROR_EN (op=11 rotates right; otherwise op=11 holds).
module shift_unit_mc #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               start,
    input  logic [WIDTH-1:0]   data_in,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [1:0]         op,
    output logic [WIDTH-1:0]   data_out,
    output logic               busy,
    output logic               ready
);

    localparam int CNT_W = (SHAMT_W > 1) ? $clog2(SHAMT_W) : 1;
    localparam logic [CNT_W-1:0] CNT_TOP = CNT_W'(SHAMT_W - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   work_q, work_d;
    logic [WIDTH-1:0]   dout_q, dout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [SHAMT_W-1:0] shamt_q, shamt_d;
    logic [1:0]         op_q, op_d;

    logic [SHAMT_W-1:0] amt;
    logic [WIDTH-1:0]   shifted;
    logic [WIDTH-1:0]   stage_val;
    logic [2*WIDTH-1:0] dbl;

    // Shift the working register by this stage's power of two per latched op.
    always_comb begin
        amt     = {{(SHAMT_W-1){1'b0}}, 1'b1} << cnt_q;
        dbl     = {work_q, work_q} >> amt;
        shifted = work_q;
        unique case (op_q)
            2'b00: shifted = work_q << amt;
            2'b01: shifted = work_q >> amt;
            2'b10: shifted = $unsigned($signed(work_q) >>> amt);
            2'b11: begin
`ifdef SHIFT_ROR_EN
                shifted = dbl[WIDTH-1:0];
`else
                shifted = work_q;
`endif
            end
            default: shifted = work_q;
        endcase
        stage_val = shamt_q[cnt_q] ? shifted : work_q;
    end

    // Next-state logic: accept in IDLE/DONE, step through stages in SHIFT.
    always_comb begin
        state_d = state_q;
        work_d  = work_q;
        dout_d  = dout_q;
        cnt_d   = cnt_q;
        shamt_d = shamt_q;
        op_d    = op_q;
        unique case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    work_d  = data_in;
                    shamt_d = shamt;
                    op_d    = op;
                    cnt_d   = CNT_TOP;
                    state_d = S_SHIFT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_SHIFT: begin
                work_d = stage_val;
                if (cnt_q == '0) begin
                    dout_d  = stage_val;
                    state_d = S_DONE;
                end else begin
                    cnt_d = cnt_q - 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    // State registers with synchronous reset that aborts any operation.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q <= S_IDLE;
            work_q  <= '0;
            dout_q  <= '0;
            cnt_q   <= CNT_TOP;
            shamt_q <= '0;
            op_q    <= '0;
        end else begin
            state_q <= state_d;
            work_q  <= work_d;
            dout_q  <= dout_d;
            cnt_q   <= cnt_d;
            shamt_q <= shamt_d;
            op_q    <= op_d;
        end
    end

    assign data_out = dout_q;
    assign busy     = (state_q == S_SHIFT);
    assign ready    = (state_q == S_DONE);

endmodule

// File: tb/tb_shift_unit_mc.sv
// Self-checking bench for shift_unit_mc: vector table, corner sequences, random ops.
// Expected op=11 behaviour follows SHIFT_ROR_EN.
module tb_shift_unit_mc;

    logic        clock = 1'b0;
    logic        reset;
    logic        start;
    logic [31:0] data_in;
    logic [4:0]  shamt;
    logic [1:0]  op;
    logic [31:0] data_out;
    logic        busy;
    logic        ready;

    int total = 0;
    int bad   = 0;

    shift_unit_mc #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clock    (clock),
        .reset    (reset),
        .start    (start),
        .data_in  (data_in),
        .shamt    (shamt),
        .op       (op),
        .data_out (data_out),
        .busy     (busy),
        .ready    (ready)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [1:0]  op;
        logic [31:0] d;
        int          sh;
        logic [31:0] exp;
    } vec_t;

    function automatic logic [31:0] ref_shift(input logic [1:0] o,
                                              input logic [31:0] d,
                                              input int sh);
        logic [63:0] w;
        case (o)
            2'b00: return d << sh;
            2'b01: return d >> sh;
            2'b10: begin
                w = {{32{d[31]}}, d};
                w = w >> sh;
                return w[31:0];
            end
            default: begin
`ifdef SHIFT_ROR_EN
                w = {d, d} >> sh;
                return w[31:0];
`else
                return d;
`endif
            end
        endcase
    endfunction

    task automatic chk(input string name, input logic [31:0] got,
                       input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    // Launch one op, then wait (bounded) for ready. lat counts edges after accept.
    task automatic run_op(input logic [1:0] o, input logic [31:0] d,
                          input logic [4:0] sh, input bit scramble,
                          output logic [31:0] res, output int lat,
                          output int bcnt);
        @(negedge clock);
        start = 1'b1;
        op = o;
        data_in = d;
        shamt = sh;
        @(posedge clock);
        #1;
        start = 1'b0;
        if (scramble) begin
            data_in = $urandom;
            shamt = 5'($urandom);
            op = 2'($urandom);
        end
        lat = 0;
        bcnt = 0;
        res = 'x;
        while (lat < 12) begin
            if (busy) bcnt++;
            if (ready) begin
                res = data_out;
                break;
            end
            @(posedge clock);
            #1;
            lat++;
        end
    endtask

    vec_t        vecs[$];
    logic [31:0] res;
    int          lat;
    int          bcnt;
    int          nready;
    int          first_k;
    int          second_k;
    logic [31:0] first_res;
    logic [31:0] second_res;
    logic [31:0] mid_out;

    initial begin
        reset = 1'b1;
        start = 1'b0;
        data_in = '0;
        shamt = '0;
        op = '0;
        repeat (3) @(posedge clock);
        #1;
        chk("reset_dout", data_out, 32'h0);
        chk("reset_busy", {31'b0, busy}, 32'h0);
        chk("reset_ready", {31'b0, ready}, 32'h0);
        reset = 1'b0;

        vecs.push_back('{2'b10, 32'h80000000, 8, 32'hFF800000});
        vecs.push_back('{2'b00, 32'h00000001, 31, 32'h80000000});
        vecs.push_back('{2'b01, 32'hF0000000, 4, 32'h0F000000});
        vecs.push_back('{2'b10, 32'h7FFFFFFF, 31, 32'h00000000});
        vecs.push_back('{2'b00, 32'h12345678, 0, 32'h12345678});
        vecs.push_back('{2'b01, 32'h9ABCDEF0, 0, 32'h9ABCDEF0});
        vecs.push_back('{2'b10, 32'h80000001, 0, 32'h80000001});
        vecs.push_back('{2'b10, 32'h80000000, 31, 32'hFFFFFFFF});
        vecs.push_back('{2'b01, 32'h80000000, 31, 32'h00000001});
`ifdef SHIFT_ROR_EN
        vecs.push_back('{2'b11, 32'h00000001, 1, 32'h80000000});
        vecs.push_back('{2'b11, 32'h12345678, 8, 32'h78123456});
`else
        vecs.push_back('{2'b11, 32'h00000001, 1, 32'h00000001});
        vecs.push_back('{2'b11, 32'h12345678, 8, 32'h12345678});
`endif

        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].d, 5'(vecs[i].sh), 1'b0, res, lat, bcnt);
            chk($sformatf("vec%0d_result", i), res, vecs[i].exp);
            chk($sformatf("vec%0d_latency", i), 32'(lat), 32'd5);
            chk($sformatf("vec%0d_busy", i), 32'(bcnt), 32'd5);
        end

        // Result holds through IDLE with ready low.
        repeat (3) @(posedge clock);
        #1;
        chk("idle_hold_dout", data_out, vecs[vecs.size()-1].exp);
        chk("idle_ready_low", {31'b0, ready}, 32'h0);

        // start held high through SHIFT with changing operands.
        @(negedge clock);
        start = 1'b1;
        op = 2'b00;
        data_in = 32'h00000001;
        shamt = 5'd1;
        @(posedge clock);
        #1;
        op = 2'b01;
        data_in = 32'hFFFFFFFF;
        shamt = 5'd3;
        nready = 0;
        first_k = -1;
        second_k = -1;
        first_res = 'x;
        second_res = 'x;
        mid_out = 'x;
        for (int k = 1; k <= 13; k++) begin
            @(posedge clock);
            #1;
            if (k == 8) mid_out = data_out;
            if (ready) begin
                nready++;
                if (first_k < 0) begin
                    first_k = k;
                    first_res = data_out;
                end else if (second_k < 0) begin
                    second_k = k;
                    second_res = data_out;
                end
            end
        end
        start = 1'b0;
        chk("held_start_nready", 32'(nready), 32'd2);
        chk("held_first_lat", 32'(first_k), 32'd5);
        chk("held_first_res", first_res, 32'h00000002);
        chk("b2b_gap", 32'(second_k - first_k), 32'd6);
        chk("b2b_second_res", second_res, 32'h1FFFFFFF);
        chk("dout_hold_during_op", mid_out, 32'h00000002);
        lat = 0;
        while (!ready && lat < 12) begin
            @(posedge clock);
            #1;
            lat++;
        end
        chk("drain_third_ready", {31'b0, ready}, 32'h1);
        chk("drain_third_res", data_out, 32'h1FFFFFFF);

        // Reset during the third SHIFT cycle aborts the op.
        @(negedge clock);
        start = 1'b1;
        op = 2'b00;
        data_in = 32'h0000000F;
        shamt = 5'd4;
        @(posedge clock);
        #1;
        start = 1'b0;
        @(posedge clock);
        #1;
        @(posedge clock);
        #1;
        chk("pre_abort_busy", {31'b0, busy}, 32'h1);
        reset = 1'b1;
        @(posedge clock);
        #1;
        reset = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_ready", {31'b0, ready}, 32'h0);
        chk("abort_dout", data_out, 32'h0);
        nready = 0;
        for (int k = 0; k < 8; k++) begin
            @(posedge clock);
            #1;
            if (ready || busy) nready++;
        end
        chk("abort_no_activity", 32'(nready), 32'd0);
        run_op(2'b00, 32'h0000000F, 5'd4, 1'b0, res, lat, bcnt);
        chk("post_abort_res", res, 32'h000000F0);
        chk("post_abort_lat", 32'(lat), 32'd5);

        // Random ops with operand scrambling during SHIFT.
        for (int n = 0; n < 1000; n++) begin
            logic [1:0]  ro;
            logic [31:0] rd;
            logic [4:0]  rs;
            ro = 2'($urandom);
            rd = $urandom;
            rs = 5'($urandom);
            run_op(ro, rd, rs, 1'b1, res, lat, bcnt);
            chk($sformatf("rand%0d op=%0d d=%h sh=%0d", n, ro, rd, rs),
                res, ref_shift(ro, rd, int'(rs)));
            if (lat != 5) chk($sformatf("rand%0d_lat", n), 32'(lat), 32'd5);
            if (bcnt != 5) chk($sformatf("rand%0d_busy", n), 32'(bcnt), 32'd5);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
